// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Buffers FU results in per-FU FIFOs and broadcasts them round-robin
//            over two registered CDB ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32,
    parameter int ROB_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fu1_result_valid,
    input  logic [TAG_W-1:0]  fu1_result_tag,
    input  logic [DATA_W-1:0] fu1_result_val,
    input  logic [ROB_W-1:0]  fu1_result_rob,
    output logic              fu1_ready,
    input  logic              fu2_result_valid,
    input  logic [TAG_W-1:0]  fu2_result_tag,
    input  logic [DATA_W-1:0] fu2_result_val,
    input  logic [ROB_W-1:0]  fu2_result_rob,
    output logic              fu2_ready,
    input  logic              fu3_result_valid,
    input  logic [TAG_W-1:0]  fu3_result_tag,
    input  logic [DATA_W-1:0] fu3_result_val,
    input  logic [ROB_W-1:0]  fu3_result_rob,
    output logic              fu3_ready,
    output logic              cdb_0_valid,
    output logic [TAG_W-1:0]  cdb_0_tag,
    output logic [DATA_W-1:0] cdb_0_val,
    output logic [ROB_W-1:0]  cdb_0_rob,
    output logic              cdb_1_valid,
    output logic [TAG_W-1:0]  cdb_1_tag,
    output logic [DATA_W-1:0] cdb_1_val,
    output logic [ROB_W-1:0]  cdb_1_rob,
    output logic              overflow
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_ent_w = TAG_W + DATA_W + ROB_W;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    logic [2:0]         in_valid;
    logic [2:0]         ready;
    logic [2:0]         push;
    logic [2:0]         pop;
    logic [2:0]         nonempty;
    logic [c_ent_w-1:0] in_ent [3];
    logic [c_ent_w-1:0] head   [3];

    logic [c_ent_w-1:0] mem_q    [3][FIFO_DEPTH];
    logic [c_ent_w-1:0] mem_d    [3][FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q [3];
    logic [c_ptr_w-1:0] wr_ptr_d [3];
    logic [c_ptr_w-1:0] rd_ptr_q [3];
    logic [c_ptr_w-1:0] rd_ptr_d [3];
    logic [c_cnt_w-1:0] count_q  [3];
    logic [c_cnt_w-1:0] count_d  [3];

    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic               gnt0_v, gnt1_v;
    logic [1:0]         gnt0_fu, gnt1_fu, cand;

    logic               cdb0_valid_q, cdb0_valid_d;
    logic               cdb1_valid_q, cdb1_valid_d;
    logic [c_ent_w-1:0] cdb0_ent_q, cdb0_ent_d;
    logic [c_ent_w-1:0] cdb1_ent_q, cdb1_ent_d;
    logic               overflow_q, overflow_d;

    function automatic logic [1:0] rr_next(input logic [1:0] fu);
        return (fu == 2'd2) ? 2'd0 : fu + 2'd1;
    endfunction

    assign in_valid  = {fu3_result_valid, fu2_result_valid, fu1_result_valid};
    assign in_ent[0] = {fu1_result_tag, fu1_result_val, fu1_result_rob};
    assign in_ent[1] = {fu2_result_tag, fu2_result_val, fu2_result_rob};
    assign in_ent[2] = {fu3_result_tag, fu3_result_val, fu3_result_rob};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_fu
            // Ready is taken from the registered count only; a same-cycle pop does not help.
            assign ready[i]    = (count_q[i] < c_depth);
            assign push[i]     = in_valid[i] & ready[i];
            assign nonempty[i] = (count_q[i] != '0);
            assign head[i]     = mem_q[i][rd_ptr_q[i]];
        end
    endgenerate

    assign fu1_ready = ready[0];
    assign fu2_ready = ready[1];
    assign fu3_ready = ready[2];

    always_comb begin
        gnt0_v  = 1'b0;
        gnt1_v  = 1'b0;
        gnt0_fu = 2'd0;
        gnt1_fu = 2'd0;
        cand    = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = 2'((int'(rr_ptr_q) + k) % 3);
            if (nonempty[cand]) begin
                if (!gnt0_v) begin
                    gnt0_v  = 1'b1;
                    gnt0_fu = cand;
                end else if (!gnt1_v) begin
                    gnt1_v  = 1'b1;
                    gnt1_fu = cand;
                end
            end
        end
    end

    always_comb begin
        pop = 3'b000;
        if (gnt0_v) pop[gnt0_fu] = 1'b1;
        if (gnt1_v) pop[gnt1_fu] = 1'b1;

        rr_ptr_d = rr_ptr_q;
        if (gnt1_v)      rr_ptr_d = rr_next(gnt1_fu);
        else if (gnt0_v) rr_ptr_d = rr_next(gnt0_fu);

        cdb0_valid_d = gnt0_v;
        cdb1_valid_d = gnt1_v;
        cdb0_ent_d   = gnt0_v ? head[gnt0_fu] : '0;
        cdb1_ent_d   = gnt1_v ? head[gnt1_fu] : '0;

        overflow_d   = overflow_q | (|(in_valid & ~ready));
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_ent[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + c_ptr_w'(1);
            end
            if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + c_ptr_w'(1);
            count_d[i] = count_q[i] + c_cnt_w'(push[i]) - c_cnt_w'(pop[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '{default: '0};
            rd_ptr_q     <= '{default: '0};
            count_q      <= '{default: '0};
            rr_ptr_q     <= 2'd0;
            cdb0_valid_q <= 1'b0;
            cdb1_valid_q <= 1'b0;
            cdb0_ent_q   <= '0;
            cdb1_ent_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb0_valid_q <= cdb0_valid_d;
            cdb1_valid_q <= cdb1_valid_d;
            cdb0_ent_q   <= cdb0_ent_d;
            cdb1_ent_q   <= cdb1_ent_d;
            overflow_q   <= overflow_d;
        end
    end

    assign cdb_0_valid                     = cdb0_valid_q;
    assign {cdb_0_tag, cdb_0_val, cdb_0_rob} = cdb0_ent_q;
    assign cdb_1_valid                     = cdb1_valid_q;
    assign {cdb_1_tag, cdb_1_val, cdb_1_rob} = cdb1_ent_q;
    assign overflow                        = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed self-checking bench for cdb_arbiter with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int ROB_W  = 6;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
        logic [ROB_W-1:0]  rob;
    } ent_t;

    typedef struct packed {
        logic [1:0] fu;
        ent_t       e;
    } sb_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        in_v;
    ent_t              in_e [3];
    logic [2:0]        rdy;
    logic              cdb_0_valid, cdb_1_valid, overflow;
    logic [TAG_W-1:0]  cdb_0_tag, cdb_1_tag;
    logic [DATA_W-1:0] cdb_0_val, cdb_1_val;
    logic [ROB_W-1:0]  cdb_0_rob, cdb_1_rob;

    sb_t         sbq [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          gcnt [3];
    logic [5:0]  tag_ctr = 6'd20;

    cdb_arbiter #(.FIFO_DEPTH(2), .TAG_W(TAG_W), .DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .reset(reset),
        .fu1_result_valid(in_v[0]), .fu1_result_tag(in_e[0].tag),
        .fu1_result_val(in_e[0].val), .fu1_result_rob(in_e[0].rob), .fu1_ready(rdy[0]),
        .fu2_result_valid(in_v[1]), .fu2_result_tag(in_e[1].tag),
        .fu2_result_val(in_e[1].val), .fu2_result_rob(in_e[1].rob), .fu2_ready(rdy[1]),
        .fu3_result_valid(in_v[2]), .fu3_result_tag(in_e[2].tag),
        .fu3_result_val(in_e[2].val), .fu3_result_rob(in_e[2].rob), .fu3_ready(rdy[2]),
        .cdb_0_valid(cdb_0_valid), .cdb_0_tag(cdb_0_tag), .cdb_0_val(cdb_0_val), .cdb_0_rob(cdb_0_rob),
        .cdb_1_valid(cdb_1_valid), .cdb_1_tag(cdb_1_tag), .cdb_1_val(cdb_1_val), .cdb_1_rob(cdb_1_rob),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Each valid broadcast must match the oldest outstanding result of some FU.
    task automatic mon();
        ent_t e;
        logic v;
        int   idx;
        bit   ok;
        for (int p = 0; p < 2; p++) begin
            v = (p == 0) ? cdb_0_valid : cdb_1_valid;
            e = (p == 0) ? {cdb_0_tag, cdb_0_val, cdb_0_rob} : {cdb_1_tag, cdb_1_val, cdb_1_rob};
            if (v) begin
                idx = -1;
                for (int i = 0; i < sbq.size(); i++) begin
                    if (sbq[i].e == e) begin
                        idx = i;
                        break;
                    end
                end
                ok = (idx >= 0);
                if (ok) begin
                    for (int i = 0; i < idx; i++)
                        if (sbq[i].fu == sbq[idx].fu) ok = 1'b0;
                end
                if (ok) begin
                    gcnt[sbq[idx].fu]++;
                    sbq.delete(idx);
                end
                chk($sformatf("cdb_%0d_scoreboard tag=%0d", p, e.tag), 64'(ok), 64'd1);
            end else begin
                chk($sformatf("cdb_%0d_idle_zero", p), 64'(e), 64'd0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic put(input int f, input logic [5:0] t, input logic [31:0] d, input logic [5:0] r);
        in_v[f] = 1'b1;
        in_e[f] = {t, d, r};
        sbq.push_back({2'(f), in_e[f]});
    endtask

    task automatic offer(input int f);
        if (rdy[f]) begin
            tag_ctr++;
            put(f, tag_ctr, $urandom, 6'($urandom));
        end else begin
            in_v[f] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_v  = 3'b000;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int   nb;
        int   win [3];
        int   prev [3];
        int   f1sent;
        bit   saw_low, saw_rec;

        in_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            in_e[i] = '0;
            gcnt[i] = 0;
            win[i]  = 0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cdb_valid", {62'd0, cdb_0_valid, cdb_1_valid}, 64'd0);
        chk("rst_cdb0_payload", 64'({cdb_0_tag, cdb_0_val, cdb_0_rob}), 64'd0);
        chk("rst_ready", 64'(rdy), 64'b111);
        chk("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;

        // Single FU1 result: visible on cdb_0 two cycles after presentation
        put(0, 6'd5, 32'hDEADBEEF, 6'd3);
        step();
        in_v = 3'b000;
        chk("t1_no_bypass", 64'(cdb_0_valid), 64'd0);
        step();
        chk("t1_cdb0_valid", 64'(cdb_0_valid), 64'd1);
        chk("t1_cdb0_tag", 64'(cdb_0_tag), 64'd5);
        chk("t1_cdb0_val", 64'(cdb_0_val), 64'hDEADBEEF);
        chk("t1_cdb0_rob", 64'(cdb_0_rob), 64'd3);
        chk("t1_cdb1_valid", 64'(cdb_1_valid), 64'd0);

        // rr_ptr now 1: FU2 and FU3 win before FU1
        put(0, 6'd10, 32'h1000_0010, 6'd10);
        put(1, 6'd11, 32'h1000_0011, 6'd11);
        put(2, 6'd12, 32'h1000_0012, 6'd12);
        step();
        in_v = 3'b000;
        step();
        chk("rr1_cdb0_tag", 64'({cdb_0_valid, cdb_0_tag}), 64'({1'b1, 6'd11}));
        chk("rr1_cdb1_tag", 64'({cdb_1_valid, cdb_1_tag}), 64'({1'b1, 6'd12}));
        step();
        chk("rr1_late_cdb0", 64'({cdb_0_valid, cdb_0_tag}), 64'({1'b1, 6'd10}));
        chk("rr1_late_cdb1", 64'(cdb_1_valid), 64'd0);

        // All three at once from rr_ptr=0
        do_reset();
        put(0, 6'd1, 32'h2000_0001, 6'd1);
        put(1, 6'd2, 32'h2000_0002, 6'd2);
        put(2, 6'd3, 32'h2000_0003, 6'd3);
        step();
        in_v = 3'b000;
        step();
        chk("all3_cdb0_tag", 64'({cdb_0_valid, cdb_0_tag}), 64'({1'b1, 6'd1}));
        chk("all3_cdb1_tag", 64'({cdb_1_valid, cdb_1_tag}), 64'({1'b1, 6'd2}));
        step();
        chk("all3_late_cdb0", 64'({cdb_0_valid, cdb_0_tag}), 64'({1'b1, 6'd3}));
        chk("all3_late_cdb1", 64'(cdb_1_valid), 64'd0);
        step();
        chk("all3_quiet", {62'd0, cdb_0_valid, cdb_1_valid}, 64'd0);

        // Fairness: every FU presents whenever ready
        do_reset();
        nb = 0;
        for (int c = 0; c < 12; c++) begin
            for (int f = 0; f < 3; f++) offer(f);
            for (int f = 0; f < 3; f++) prev[f] = gcnt[f];
            step();
            if (cdb_0_valid && nb < 6) begin
                chk("fair_both_ports", 64'(cdb_1_valid), 64'd1);
                for (int f = 0; f < 3; f++) win[f] += gcnt[f] - prev[f];
                nb++;
            end
        end
        in_v = 3'b000;
        repeat (5) step();
        for (int f = 0; f < 3; f++) chk($sformatf("fair_grants_fu%0d", f + 1), 64'(win[f]), 64'd4);
        chk("fair_drained", 64'(sbq.size()), 64'd0);
        chk("fair_overflow", 64'(overflow), 64'd0);

        // Backpressure on FU1 while FU2/FU3 stream
        do_reset();
        f1sent  = 0;
        saw_low = 1'b0;
        saw_rec = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (!rdy[0]) saw_low = 1'b1;
            else if (saw_low) saw_rec = 1'b1;
            if (f1sent < 4 && rdy[0]) begin
                offer(0);
                f1sent++;
            end else begin
                in_v[0] = 1'b0;
            end
            offer(1);
            offer(2);
            step();
        end
        in_v = 3'b000;
        repeat (6) step();
        chk("bp_fu1_sent", 64'(f1sent), 64'd4);
        chk("bp_ready_dropped", 64'(saw_low), 64'd1);
        chk("bp_ready_returned", 64'(saw_rec), 64'd1);
        chk("bp_drained", 64'(sbq.size()), 64'd0);
        chk("bp_overflow", 64'(overflow), 64'd0);

        // Overflow: FU3 presents while full; that result must never broadcast
        do_reset();
        for (int f = 0; f < 3; f++) offer(f);
        step();
        for (int f = 0; f < 3; f++) offer(f);
        step();
        chk("ovf_fu3_full", 64'(rdy[2]), 64'd0);
        chk("ovf_before", 64'(overflow), 64'd0);
        in_v    = 3'b100;
        in_e[2] = {6'd63, 32'hBAD0BAD0, 6'd1};
        step();
        in_v = 3'b000;
        chk("ovf_set", 64'(overflow), 64'd1);
        repeat (6) step();
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_drained", 64'(sbq.size()), 64'd0);

        // Asynchronous reset with results still queued
        for (int f = 0; f < 3; f++) offer(f);
        step();
        for (int f = 0; f < 3; f++) offer(f);
        step();
        in_v = 3'b000;
        chk("arst_pre_active", 64'(cdb_0_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_cdb_valid", {62'd0, cdb_0_valid, cdb_1_valid}, 64'd0);
        chk("arst_ready", 64'(rdy), 64'b111);
        chk("arst_overflow", 64'(overflow), 64'd0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("arst_post_quiet", {62'd0, cdb_0_valid, cdb_1_valid}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
